// File: rtl/shell_ctrl.sv
// shell_ctrl: single-shell projectile engine for one tank.
// Launches on a trigger edge, steps once per frame under gravity, checks for
// impact on the opposing tank, and owns that tank's hit-point counter.
module shell_ctrl #(
  parameter int unsigned SHELL_VX       = 3,
  parameter int unsigned MUZZLE_DY      = 8,
  parameter int unsigned G_DIV          = 4,
  parameter int unsigned VY_MAX         = 15,
  parameter int unsigned EXPLODE_FRAMES = 8,
  parameter int unsigned HP_INIT        = 10,
  parameter int unsigned SHELL_SIZE     = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       shoot,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] Direction,
  input  logic [9:0] y_component,
  input  logic [9:0] TargetX,
  input  logic [9:0] TargetY,
  input  logic [9:0] TargetS,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic [9:0] ShellS,
  output logic       ShellVisible,
  output logic       explode,
  output logic       hit,
  output logic [3:0] TargetHP,
  output logic       game_over
);

  localparam int unsigned PW   = 11;
  localparam int unsigned DW   = PW + 1;
  localparam int unsigned VW   = 6;
  localparam int unsigned YW   = 10;
  localparam int unsigned HW   = 4;
  localparam int unsigned GCW  = (G_DIV > 1) ? $clog2(G_DIV) : 1;
  localparam int unsigned ECW  = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam int unsigned XMAX = 639;
  localparam int unsigned YMAX = 479;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLIGHT = 2'd1;
  localparam logic [1:0] S_IMPACT = 2'd2;

  logic [1:0]     r_state, w_state_nxt;
  logic [PW-1:0]  r_px, w_px_nxt;
  logic [PW-1:0]  r_py, w_py_nxt;
  logic [VW-1:0]  r_vx, w_vx_nxt;
  logic [VW-1:0]  r_vy, w_vy_nxt;
  logic [GCW-1:0] r_gcnt, w_gcnt_nxt;
  logic [ECW-1:0] r_ecnt, w_ecnt_nxt;
  logic [HW-1:0]  r_hp, w_hp_nxt;
  logic           r_hit, w_hit_nxt;
  logic           r_shoot_q;
  logic           r_armed;

  logic           w_launch;
  logic [DW-1:0]  w_dx, w_dy, w_adx, w_ady, w_lim;
  logic [DW-1:0]  w_nx, w_ny;
  logic           w_hit_det, w_miss;
  logic [YW-1:0]  w_yc_neg;
  logic [VW-1:0]  w_vy_launch, w_vy_grav;
  logic           w_unused_dir;

  assign w_unused_dir = Direction[1];

  // A trigger already held through reset must be released before it can fire
  assign w_launch = shoot & ~r_shoot_q & r_armed;

  // Box overlap between shell centre and target, using sign-extended distances
  assign w_dx      = {r_px[PW-1], r_px} - {2'b00, TargetX};
  assign w_dy      = {r_py[PW-1], r_py} - {2'b00, TargetY};
  assign w_adx     = w_dx[DW-1] ? (DW'(0) - w_dx) : w_dx;
  assign w_ady     = w_dy[DW-1] ? (DW'(0) - w_dy) : w_dy;
  assign w_lim     = {2'b00, TargetS} + DW'(SHELL_SIZE);
  assign w_hit_det = (w_adx <= w_lim) && (w_ady <= w_lim);

  // Candidate next position and playfield exit test (top edge is open)
  assign w_nx   = {r_px[PW-1], r_px} + {{(DW-VW){r_vx[VW-1]}}, r_vx};
  assign w_ny   = {r_py[PW-1], r_py} + {{(DW-VW){r_vy[VW-1]}}, r_vy};
  assign w_miss = w_nx[DW-1] || (w_nx > DW'(XMAX)) ||
                  (!w_ny[DW-1] && (w_ny > DW'(YMAX)));

  // Launch vertical speed: negated aim, clamped to +/-VY_MAX
  assign w_yc_neg = YW'(0) - y_component;
  always_comb begin
    w_vy_launch = w_yc_neg[VW-1:0];
    if (y_component[YW-1]) begin
      if (y_component < YW'(1024 - VY_MAX)) w_vy_launch = VW'(VY_MAX);
    end else if (y_component > YW'(VY_MAX)) begin
      w_vy_launch = VW'(0) - VW'(VY_MAX);
    end
  end

  // Gravity step with downward speed limit
  assign w_vy_grav = ($signed(r_vy) >= $signed(VW'(VY_MAX))) ? VW'(VY_MAX)
                                                               : r_vy + VW'(1);

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_vx_nxt    = r_vx;
    w_vy_nxt    = r_vy;
    w_gcnt_nxt  = r_gcnt;
    w_ecnt_nxt  = r_ecnt;
    w_hp_nxt    = r_hp;
    w_hit_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_px_nxt    = {1'b0, TankX};
          w_py_nxt    = {1'b0, TankY} - PW'(MUZZLE_DY);
          w_vx_nxt    = Direction[0] ? VW'(SHELL_VX) : (VW'(0) - VW'(SHELL_VX));
          w_vy_nxt    = w_vy_launch;
          w_gcnt_nxt  = '0;
          w_state_nxt = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (w_hit_det) begin
          w_hit_nxt   = 1'b1;
          w_hp_nxt    = (r_hp == '0) ? r_hp : r_hp - HW'(1);
          w_ecnt_nxt  = ECW'(EXPLODE_FRAMES - 1);
          w_state_nxt = S_IMPACT;
        end else if (w_miss) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_px_nxt = w_nx[PW-1:0];
          w_py_nxt = w_ny[PW-1:0];
          if (r_gcnt == GCW'(G_DIV - 1)) begin
            w_gcnt_nxt = '0;
            w_vy_nxt   = w_vy_grav;
          end else begin
            w_gcnt_nxt = r_gcnt + GCW'(1);
          end
        end
      end
      S_IMPACT: begin
        if (r_ecnt == '0) w_state_nxt = S_IDLE;
        else              w_ecnt_nxt  = r_ecnt - ECW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_px      <= '0;
      r_py      <= '0;
      r_vx      <= '0;
      r_vy      <= '0;
      r_gcnt    <= '0;
      r_ecnt    <= '0;
      r_hp      <= HW'(HP_INIT);
      r_hit     <= 1'b0;
      r_shoot_q <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_px      <= w_px_nxt;
      r_py      <= w_py_nxt;
      r_vx      <= w_vx_nxt;
      r_vy      <= w_vy_nxt;
      r_gcnt    <= w_gcnt_nxt;
      r_ecnt    <= w_ecnt_nxt;
      r_hp      <= w_hp_nxt;
      r_hit     <= w_hit_nxt;
      r_shoot_q <= shoot;
      r_armed   <= r_armed | ~shoot;
    end
  end

  assign ShellX       = r_px[9:0];
  assign ShellY       = r_py[9:0];
  assign ShellS       = 10'(SHELL_SIZE);
  assign ShellVisible = (r_state == S_FLIGHT) && !r_py[PW-1];
  assign explode      = (r_state == S_IMPACT);
  assign hit          = r_hit;
  assign TargetHP     = r_hp;
  assign game_over    = (r_hp == '0);

endmodule

// File: tb/tb_shell_ctrl.sv
// Directed bench for shell_ctrl: launch, motion, trigger edge, hit, miss, clamp, abort.
module tb_shell_ctrl;

  logic       frame_clk;
  logic       Reset;
  logic       shoot;
  logic [9:0] TankX, TankY;
  logic [1:0] Direction;
  logic [9:0] y_component;
  logic [9:0] TargetX, TargetY, TargetS;
  logic [9:0] ShellX, ShellY, ShellS;
  logic       ShellVisible, explode, hit;
  logic [3:0] TargetHP;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  shell_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .shoot       (shoot),
    .TankX       (TankX),
    .TankY       (TankY),
    .Direction   (Direction),
    .y_component (y_component),
    .TargetX     (TargetX),
    .TargetY     (TargetY),
    .TargetS     (TargetS),
    .ShellX      (ShellX),
    .ShellY      (ShellY),
    .ShellS      (ShellS),
    .ShellVisible(ShellVisible),
    .explode     (explode),
    .hit         (hit),
    .TargetHP    (TargetHP),
    .game_over   (game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Fresh 0->1 on shoot; launch lands on the second edge
  task automatic fire();
    shoot = 1'b0;
    tick();
    shoot = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while ((ShellVisible || explode) && n < budget) begin
      tick();
      n++;
    end
    ok = !(ShellVisible || explode);
  endtask

  task automatic far_target();
    TargetX = 10'd600; TargetY = 10'd50; TargetS = 10'd4;
  endtask

  task automatic test_reset();
    bit seen;
    Reset = 1'b0; shoot = 1'b1;
    TankX = 10'd140; TankY = 10'd200; Direction = 2'b01; y_component = 10'd0;
    far_target();
    tick(); tick();
    total++;
    if (ShellX !== 10'd0 || ShellY !== 10'd0 || ShellVisible !== 1'b0 || explode !== 1'b0 || hit !== 1'b0) begin
      bad++;
      $display("FAIL reset_zero: got x=%0d y=%0d vis=%0b exp=%0b hit=%0b want all 0", ShellX, ShellY, ShellVisible, explode, hit);
    end
    total++;
    if (TargetHP !== 4'd10) begin bad++; $display("FAIL reset_hp: got %0d want 10", TargetHP); end
    total++;
    if (game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over: got %0b want 0", game_over); end
    total++;
    if (ShellS !== 10'd2) begin bad++; $display("FAIL shell_size: got %0d want 2", ShellS); end
    Reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (ShellVisible || explode) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL reset_held_shoot: got launch=%0b want 0", seen); end
    shoot = 1'b0;
    tick();
  endtask

  task automatic test_flat();
    int ex[5] = '{143, 146, 149, 152, 155};
    int ey[5] = '{192, 192, 192, 192, 193};
    bit ok;
    far_target();
    TankX = 10'd140; TankY = 10'd200; Direction = 2'b01; y_component = 10'd0;
    fire();
    total++;
    if (ShellX !== 10'd140 || ShellY !== 10'd192 || ShellVisible !== 1'b1) begin
      bad++;
      $display("FAIL flat_launch: got x=%0d y=%0d vis=%0b want 140 192 1", ShellX, ShellY, ShellVisible);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ShellX !== 10'(ex[i]) || ShellY !== 10'(ey[i])) begin
        bad++;
        $display("FAIL flat_move%0d: got x=%0d y=%0d want %0d %0d", i + 1, ShellX, ShellY, ex[i], ey[i]);
      end
    end
    shoot = 1'b0;
    wait_idle(300, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL flat_end: got idle=%0b want 1", ok); end
    total++;
    if (TargetHP !== 4'd10) begin bad++; $display("FAIL flat_miss_hp: got %0d want 10", TargetHP); end
  endtask

  task automatic test_held();
    int  launches = 0;
    bit  prev;
    bit  ok;
    shoot = 1'b0;
    tick(); tick();
    shoot = 1'b1;
    prev = ShellVisible;
    repeat (200) begin
      tick();
      if (ShellVisible && !prev) launches++;
      prev = ShellVisible;
    end
    total++;
    if (launches != 1) begin bad++; $display("FAIL held_launches: got %0d want 1", launches); end
    shoot = 1'b0;
    tick();
    shoot = 1'b1;
    tick();
    total++;
    if (ShellVisible !== 1'b1 || ShellX !== 10'd140) begin
      bad++;
      $display("FAIL held_refire: got vis=%0b x=%0d want 1 140", ShellVisible, ShellX);
    end
    shoot = 1'b0;
    wait_idle(300, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL held_end: got idle=%0b want 1", ok); end
  endtask

  task automatic test_hit();
    int moves = 0;
    int n;
    TargetX = 10'd152; TargetY = 10'd192; TargetS = 10'd4;
    TankX = 10'd140; TankY = 10'd200; Direction = 2'b01; y_component = 10'd0;
    fire();
    while (hit !== 1'b1 && moves < 4) begin
      tick();
      moves++;
    end
    total++;
    if (hit !== 1'b1) begin bad++; $display("FAIL hit_pulse: got %0b want 1", hit); end
    total++;
    if (moves != 3) begin bad++; $display("FAIL hit_moves: got %0d want 3", moves); end
    total++;
    if (TargetHP !== 4'd9) begin bad++; $display("FAIL hit_hp: got %0d want 9", TargetHP); end
    total++;
    if (ShellX !== 10'd146 || explode !== 1'b1) begin
      bad++;
      $display("FAIL hit_freeze: got x=%0d explode=%0b want 146 1", ShellX, explode);
    end
    n = 1;
    shoot = 1'b0;
    tick();
    total++;
    if (hit !== 1'b0) begin bad++; $display("FAIL hit_one_frame: got %0b want 0", hit); end
    while (explode && n < 20) begin
      n++;
      tick();
    end
    total++;
    if (n != 8) begin bad++; $display("FAIL explode_frames: got %0d want 8", n); end
    total++;
    if (explode !== 1'b0 || ShellVisible !== 1'b0 || ShellX !== 10'd146) begin
      bad++;
      $display("FAIL hit_idle: got explode=%0b vis=%0b x=%0d want 0 0 146", explode, ShellVisible, ShellX);
    end
    far_target();
  endtask

  task automatic test_left_exit();
    far_target();
    TankX = 10'd5; TankY = 10'd200; Direction = 2'b00; y_component = 10'd0;
    fire();
    total++;
    if (ShellX !== 10'd5) begin bad++; $display("FAIL left_launch: got %0d want 5", ShellX); end
    tick();
    total++;
    if (ShellX !== 10'd2 || ShellVisible !== 1'b1) begin
      bad++;
      $display("FAIL left_step: got x=%0d vis=%0b want 2 1", ShellX, ShellVisible);
    end
    tick();
    total++;
    if (ShellVisible !== 1'b0 || explode !== 1'b0 || ShellX !== 10'd2) begin
      bad++;
      $display("FAIL left_miss: got vis=%0b explode=%0b x=%0d want 0 0 2", ShellVisible, explode, ShellX);
    end
    total++;
    if (TargetHP !== 4'd9) begin bad++; $display("FAIL left_hp: got %0d want 9", TargetHP); end
    shoot = 1'b0;
  endtask

  task automatic test_aim_clamp();
    bit ok;
    far_target();
    TankX = 10'd300; TankY = 10'd200; Direction = 2'b01;
    y_component = 10'd924;
    fire();
    tick();
    total++;
    if (ShellX !== 10'd303 || ShellY !== 10'd207) begin
      bad++;
      $display("FAIL clamp_down: got x=%0d y=%0d want 303 207", ShellX, ShellY);
    end
    shoot = 1'b0;
    wait_idle(100, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL clamp_down_end: got idle=%0b want 1", ok); end
  endtask

  task automatic test_abort();
    far_target();
    TankX = 10'd300; TankY = 10'd200; Direction = 2'b01;
    y_component = 10'd100;
    fire();
    tick();
    total++;
    if (ShellY !== 10'd177) begin bad++; $display("FAIL clamp_up: got y=%0d want 177", ShellY); end
    repeat (14) tick();
    total++;
    if (ShellX !== 10'd345 || ShellY !== 10'd1012 || ShellVisible !== 1'b0) begin
      bad++;
      $display("FAIL above_screen: got x=%0d y=%0d vis=%0b want 345 1012 0", ShellX, ShellY, ShellVisible);
    end
    shoot = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    total++;
    if (ShellX !== 10'd0 || ShellY !== 10'd0 || ShellVisible !== 1'b0 || explode !== 1'b0) begin
      bad++;
      $display("FAIL abort_clear: got x=%0d y=%0d vis=%0b exp=%0b want 0 0 0 0", ShellX, ShellY, ShellVisible, explode);
    end
    total++;
    if (TargetHP !== 4'd10) begin bad++; $display("FAIL abort_hp: got %0d want 10", TargetHP); end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    int  exp_hp = 10;
    int  m;
    int  n;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    shoot = 1'b0;
    tick();
    TargetX = 10'd152; TargetY = 10'd192; TargetS = 10'd4;
    TankX = 10'd140; TankY = 10'd200; Direction = 2'b01; y_component = 10'd0;
    for (int s = 0; s < 11; s++) begin
      fire();
      m = 0;
      while (hit !== 1'b1 && m < 10) begin
        tick();
        m++;
      end
      total++;
      if (hit !== 1'b1) begin bad++; $display("FAIL sat_hit%0d: got %0b want 1", s + 1, hit); end
      exp_hp = (exp_hp > 0) ? exp_hp - 1 : 0;
      total++;
      if (TargetHP !== 4'(exp_hp)) begin
        bad++;
        $display("FAIL sat_hp%0d: got %0d want %0d", s + 1, TargetHP, exp_hp);
      end
      if (s == 9) begin
        total++;
        if (game_over !== 1'b1) begin bad++; $display("FAIL game_over: got %0b want 1", game_over); end
      end
      n = 0;
      while (explode && n < 20) begin
        tick();
        n++;
      end
    end
    total++;
    if (TargetHP !== 4'd0 || game_over !== 1'b1) begin
      bad++;
      $display("FAIL sat_final: got hp=%0d go=%0b want 0 1", TargetHP, game_over);
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_held();
    test_hit();
    test_left_exit();
    test_aim_clamp();
    test_abort();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
